// File: rtl/uart_receiver.sv
// 16750-compatible UART receive engine: oversampled start-bit validation, 5-8 data bits,
// parity and stop-bit checking, break detection, and a one-cycle RXFINISHED per character.
module uart_receiver #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXCLK,
    input  logic       CLEAR,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       SIN,
    output logic [7:0] DOUT,
    output logic       PE,
    output logic       FE,
    output logic       BI,
    output logic       RXFINISHED
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRKWAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sin_s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   pe_q, pe_d;
    logic                   ones_q, ones_d;
    logic                   commit;
    logic                   fe_new;
    logic                   bi_new;
    logic [2:0]             last_idx;
    logic [7:0]             mask;
    logic                   data_xor;
    logic                   par_exp;
    logic                   unused_stb;

    // The receiver only checks the first stop bit, so the stop-bit count is not needed.
    assign unused_stb = STB;

    assign sin_s    = sync_q[SYNC_STAGES-1];
    assign last_idx = 3'd4 + {1'b0, WLS};
    assign mask     = 8'hFF >> (3'd3 - {1'b0, WLS});
    assign data_xor = ^(shift_q & mask);
    assign par_exp  = SP ? ~EPS : (EPS ? data_xor : ~data_xor);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SIN};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pe_d    = pe_q;
        ones_d  = ones_q;
        commit  = 1'b0;
        fe_new  = 1'b0;
        bi_new  = 1'b0;
        if (RXCLK) begin
            case (state_q)
                IDLE: begin
                    if (!sin_s) begin
                        state_d = START;
                        cnt_d   = CW'(1);
                    end
                end
                START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_d = '0;
                        if (sin_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            idx_d   = '0;
                            shift_d = '0;
                            pe_d    = 1'b0;
                            ones_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = sin_s;
                        ones_d         = ones_q | sin_s;
                        if (idx_q >= last_idx) begin
                            state_d = PEN ? PAR : STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PAR: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_d   = '0;
                        pe_d    = (sin_s != par_exp);
                        ones_d  = ones_q | sin_s;
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_d   = '0;
                        commit  = 1'b1;
                        fe_new  = ~sin_s;
                        bi_new  = ~ones_q & ~sin_s;
                        // A low stop bit parks in BRKWAIT so a held break yields one character.
                        state_d = sin_s ? IDLE : BRKWAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BRKWAIT: begin
                    if (sin_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        if (CLEAR) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            pe_d    = 1'b0;
            ones_d  = 1'b0;
            commit  = 1'b0;
            fe_new  = 1'b0;
            bi_new  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            pe_q       <= 1'b0;
            ones_q     <= 1'b0;
            DOUT       <= '0;
            PE         <= 1'b0;
            FE         <= 1'b0;
            BI         <= 1'b0;
            RXFINISHED <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            pe_q       <= pe_d;
            ones_q     <= ones_d;
            RXFINISHED <= commit;
            if (commit) begin
                DOUT <= bi_new ? 8'h00 : (shift_d & mask);
                PE   <= pe_d & ~bi_new;
                FE   <= fe_new;
                BI   <= bi_new;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized frames checked
// against a character-level model of the serial line format.
module tb_uart_receiver;

    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = 16 * TICK_DIV;

    typedef struct packed {
        logic [7:0] dout;
        logic       pe;
        logic       fe;
        logic       bi;
    } rec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXCLK = 1'b0;
    logic       CLEAR = 1'b0;
    logic [1:0] WLS = 2'b11;
    logic       STB = 1'b0;
    logic       PEN = 1'b0;
    logic       EPS = 1'b0;
    logic       SP = 1'b0;
    logic       SIN = 1'b1;
    logic [7:0] DOUT;
    logic       PE;
    logic       FE;
    logic       BI;
    logic       RXFINISHED;

    int   total = 0;
    int   bad = 0;
    rec_t obs_q[$];
    rec_t last_exp = '0;

    uart_receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .RXCLK(RXCLK), .CLEAR(CLEAR), .WLS(WLS), .STB(STB),
        .PEN(PEN), .EPS(EPS), .SP(SP), .SIN(SIN), .DOUT(DOUT), .PE(PE), .FE(FE),
        .BI(BI), .RXFINISHED(RXFINISHED)
    );

    always #5 CLK = ~CLK;

    initial begin
        int div = 0;
        forever begin
            @(posedge CLK);
            #1;
            RXCLK = (div == TICK_DIV - 1);
            div = (div + 1) % TICK_DIV;
        end
    end

    // Every cycle with RXFINISHED high is recorded, so a wide strobe shows up as extra entries.
    always @(negedge CLK) begin
        if (RXFINISHED === 1'b1) obs_q.push_back({DOUT, PE, FE, BI});
    end

    function automatic rec_t model(logic [7:0] data, logic [1:0] wls, logic pen, logic eps,
                                   logic sp, logic par, logic stop);
        rec_t r;
        int   nb = 5 + int'(wls);
        int   ones = 0;
        logic want;
        r.dout = 8'h00;
        for (int i = 0; i < nb; i++) begin
            r.dout[i] = data[i];
            ones += int'(data[i]);
        end
        if (sp) want = !eps;
        else if (eps) want = (ones % 2) == 1;
        else want = (ones % 2) == 0;
        r.pe = pen && (par != want);
        r.fe = !stop;
        r.bi = (r.dout == 8'h00) && !(pen && par) && !stop;
        if (r.bi) begin
            r.dout = 8'h00;
            r.pe = 1'b0;
            r.fe = 1'b1;
        end
        return r;
    endfunction

    task automatic drive_bit(logic b);
        SIN = b;
        repeat (BIT_CLK) @(posedge CLK);
        #1;
    endtask

    task automatic set_cfg(logic [1:0] wls, logic pen, logic eps, logic sp);
        WLS = wls;
        PEN = pen;
        EPS = eps;
        SP = sp;
    endtask

    task automatic send_frame(logic [7:0] data, logic par, logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 5 + int'(WLS); i++) drive_bit(data[i]);
        if (PEN) drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic idle_bits(int n);
        SIN = 1'b1;
        repeat (n * BIT_CLK) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if ({DOUT, PE, FE, BI, RXFINISHED} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h want=000", {DOUT, PE, FE, BI, RXFINISHED});
        end
        @(posedge CLK);
        #1;
        idle_bits(1);
    endtask

    task automatic test_frame(string name, logic [7:0] data, logic par, logic stop);
        rec_t exp_r = model(data, WLS, PEN, EPS, SP, par, stop);
        obs_q.delete();
        send_frame(data, par, stop);
        idle_bits(2);
        total++;
        if (obs_q.size() !== 1) begin
            bad++;
            $display("[TB] FAIL %s_strobes got=%0d want=1", name, obs_q.size());
        end
        if (obs_q.size() > 0) begin
            total++;
            if (obs_q[0] !== exp_r) begin
                bad++;
                $display("[TB] FAIL %s_char got=%h want=%h", name, obs_q[0], exp_r);
            end
        end
        last_exp = exp_r;
    endtask

    task automatic test_8n1();
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        test_frame("8n1_a5", 8'hA5, 1'b0, 1'b1);
    endtask

    task automatic test_parity();
        set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
        test_frame("7e1_bad", 8'h41, 1'b1, 1'b1);
        test_frame("7e1_good", 8'h41, 1'b0, 1'b1);
        set_cfg(2'b00, 1'b1, 1'b0, 1'b1);
        test_frame("5stick", 8'h1F, 1'b1, 1'b1);
    endtask

    task automatic test_break();
        rec_t exp_r;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        exp_r = model(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        obs_q.delete();
        SIN = 1'b0;
        repeat (30 * BIT_CLK) @(posedge CLK);
        #1;
        total++;
        if (obs_q.size() !== 1) begin
            bad++;
            $display("[TB] FAIL break_strobes got=%0d want=1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            total++;
            if (obs_q[0] !== exp_r) begin
                bad++;
                $display("[TB] FAIL break_char got=%h want=%h", obs_q[0], exp_r);
            end
        end
        idle_bits(3);
        total++;
        if (obs_q.size() !== 1) begin
            bad++;
            $display("[TB] FAIL break_release_strobes got=%0d want=1", obs_q.size());
        end
        last_exp = exp_r;
    endtask

    task automatic test_glitch();
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        obs_q.delete();
        SIN = 1'b0;
        repeat (BIT_CLK / 4) @(posedge CLK);
        #1;
        idle_bits(2);
        total++;
        if (obs_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL glitch_strobes got=%0d want=0", obs_q.size());
        end
        test_frame("after_glitch", 8'h3C, 1'b0, 1'b1);
    endtask

    task automatic test_clear();
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        obs_q.delete();
        // 0xF8 keeps the line high from data bit 3 onward, so no stray start follows the abort.
        fork
            send_frame(8'hF8, 1'b0, 1'b1);
            begin
                repeat (4 * BIT_CLK + BIT_CLK / 2) @(posedge CLK);
                #1;
                CLEAR = 1'b1;
                @(posedge CLK);
                #1;
                CLEAR = 1'b0;
            end
        join
        idle_bits(2);
        total++;
        if (obs_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL clear_strobes got=%0d want=0", obs_q.size());
        end
        total++;
        if ({DOUT, PE, FE, BI} !== last_exp) begin
            bad++;
            $display("[TB] FAIL clear_hold got=%h want=%h", {DOUT, PE, FE, BI}, last_exp);
        end
        test_frame("after_clear", 8'h5A, 1'b0, 1'b1);
    endtask

    task automatic test_midframe_reset();
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        obs_q.delete();
        fork
            send_frame(8'hF8, 1'b0, 1'b1);
            begin
                repeat (4 * BIT_CLK + BIT_CLK / 2) @(posedge CLK);
                #1;
                RST = 1'b1;
                @(posedge CLK);
                #1;
                RST = 1'b0;
            end
        join
        idle_bits(2);
        total++;
        if (obs_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL rst_strobes got=%0d want=0", obs_q.size());
        end
        total++;
        if ({DOUT, PE, FE, BI} !== 11'h000) begin
            bad++;
            $display("[TB] FAIL rst_outputs got=%h want=000", {DOUT, PE, FE, BI});
        end
        test_frame("after_rst", 8'h5A, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            logic [7:0] data = 8'($urandom);
            logic       par = 1'($urandom_range(0, 1));
            logic       stop = ($urandom_range(0, 5) != 0);
            set_cfg(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (n == 3) data = 8'h00;
            test_frame($sformatf("rand%0d", n), data, par, stop);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] data[4];
        rec_t       exp_r;
        set_cfg(2'b11, 1'b1, 1'b1, 1'b0);
        obs_q.delete();
        for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) send_frame(data[i], ^data[i], 1'b1);
        idle_bits(2);
        total++;
        if (obs_q.size() !== 4) begin
            bad++;
            $display("[TB] FAIL b2b_strobes got=%0d want=4", obs_q.size());
        end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            exp_r = model(data[i], 2'b11, 1'b1, 1'b1, 1'b0, ^data[i], 1'b1);
            total++;
            if (obs_q[i] !== exp_r) begin
                bad++;
                $display("[TB] FAIL b2b_char%0d got=%h want=%h", i, obs_q[i], exp_r);
            end
        end
    endtask

    initial begin
        @(posedge CLK);
        #1;
        test_reset();
        test_8n1();
        test_parity();
        test_break();
        test_glitch();
        test_clear();
        test_midframe_reset();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel receive engine for the 16750-compatible UART, the counterpart of the transmit engine in the same core. It oversamples SIN on an RXCLK enable (16x baud), detects and validates start bits, and assembles 5-8 data bits. It checks parity and the stop bit, and flags break conditions. Each completed character is handed to the receive FIFO/register logic with a one-cycle RXFINISHED strobe.

Parameters:
OVERSAMPLE, 16, RXCLK ticks per bit; must be even and >= 4.
SYNC_STAGES, 2, flip-flop stages in the SIN metastability synchroniser; must be >= 2.

Ports:
CLK  input  1  system clock; all logic is on the rising edge.
RST  input  1  synchronous reset, active-high.
RXCLK  input  1  one-CLK-wide baud enable at OVERSAMPLE x baud rate.
CLEAR  input  1  synchronous abort: discard the frame in progress.
WLS  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
STB  input  1  stop bits setting (1.5/2 on transmit); the receiver checks only the first stop bit.
PEN  input  1  parity enable.
EPS  input  1  even parity select.
SP  input  1  stick parity.
SIN  input  1  asynchronous serial input, idle high.
DOUT  output  8  received character, LSB first on the line; unused upper bits are 0.
PE  output  1  parity error for DOUT.
FE  output  1  framing error for DOUT (first stop bit sampled low).
BI  output  1  break indication for DOUT.
RXFINISHED  output  1  one-CLK pulse: DOUT/PE/FE/BI updated.

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-high (RST). On RST: state=IDLE, synchroniser=all 1s, counters=0, DOUT=0, PE=FE=BI=0, RXFINISHED=0.
- Sampling: SIN passes through SYNC_STAGES flops clocked every CLK. All FSM and counter activity advances only on CLK edges where RXCLK=1. The tick counter is log2(OVERSAMPLE) bits wide.
- IDLE: on a tick with synchronised SIN=0, go to START and set tick counter=1.
- START: on the tick where the counter reaches OVERSAMPLE/2 (mid-bit):
  - SIN=1: false start; return to IDLE, no strobe, outputs unchanged.
  - SIN=0: go to DATA, counter=0, bit index=0, clear the all-zero tracker.
- DATA: sample one bit every OVERSAMPLE ticks into shift register position [bit index]. After bit index = 4+WLS, go to PAR if PEN=1, else STOP.
- PAR: sample one bit. Expected value:
  - SP=1: ~EPS.
  - SP=0, EPS=1: XOR of the data bits.
  - SP=0, EPS=0: ~XOR of the data bits.
  - Mismatch sets the pending PE.
- STOP: sample one bit. FE_pend = ~sample. BI_pend = 1 if the start bit, all data bits, the parity bit (if present) and the stop sample were all 0.
- Commit: in the CLK cycle after the stop-sample tick:
  - DOUT loads the masked shift register; PE, FE and BI load their pending values; RXFINISHED=1 for exactly one CLK.
  - PE/FE/BI/DOUT then hold until the next commit.
  - BI=1 forces DOUT=0, FE=1 and PE=0.
- After commit:
  - Stop sample=1: go to IDLE immediately. Back-to-back frames need no idle time; the next start edge is searched from the following tick.
  - Stop sample=0: go to BRKWAIT, which stays until synchronised SIN=1 on a tick, then goes to IDLE. This prevents a held break from generating repeated characters.
- CLEAR=1: on any cycle, go to IDLE, reset counters and discard pending flags. No strobe is issued; DOUT/PE/FE/BI keep their last committed values. CLEAR has priority over a simultaneous commit: the commit is dropped.
- Config changes: WLS/PEN/EPS/SP changed mid-frame take effect at the next bit decision; software must not do this.
- States: IDLE, START, DATA, PAR, STOP, BRKWAIT. Any unreachable encoding goes to IDLE.
- Latency: RXFINISHED comes SYNC_STAGES + 1 CLK after the stop-bit mid-sample edge of SIN.

Test Plan:
- 8N1 (WLS=11, PEN=0), send 0xA5 at 16x RXCLK -> single RXFINISHED, DOUT=0xA5, PE=FE=BI=0.
- 7E1 (WLS=10, PEN=1, EPS=1, SP=0), send 0x41 with parity bit 1 -> DOUT=0x41, PE=1. Repeat with parity 0 -> PE=0.
- 5-bit stick parity (WLS=00, PEN=1, SP=1, EPS=0), send 0x1F with parity 1 -> DOUT=0x1F, PE=0. Upper DOUT bits are 0.
- Line held low for 3 frame times -> exactly one RXFINISHED with DOUT=0x00, BI=1, FE=1. No further strobe until SIN returns high and a new start occurs.
- 0.25-bit low glitch on idle SIN -> no RXFINISHED. A following valid 0x3C is received correctly.
- Assert CLEAR (1 CLK) at data bit 3 of a frame -> no strobe for that frame, outputs unchanged. The next frame 0x5A is received. Repeat with RST mid-frame -> all outputs 0, then 0x5A is received.
